// File: rtl/ceespu_bp_pkg.sv
// Shared definitions for the ceespu gshare predictor: 2-bit counter encoding,
// init/run state encoding and the saturating counter update.
package ceespu_bp_pkg;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != STRONG_T) nxt = state + 2'd1;
    end else begin
      if (state != STRONG_NT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ceespu_pht_ram.sv
// Pattern history table: 2^ADDR_BITS x 2-bit counters, async read, sync write.
// The write port either stores WEAK_NT (init) or applies a saturating update in place.
module ceespu_pht_ram
  import ceespu_bp_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [1:0]           rd_data,
  input  logic                 wr_en,
  input  logic                 wr_init,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 wr_taken
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [1:0] pht_q [DEPTH];

  assign rd_data = pht_q[rd_addr];

  // Read-modify-write on the write address keeps the external interface to one read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pht_q[wr_addr] <= wr_init ? WEAK_NT : sat_update(pht_q[wr_addr], wr_taken);
    end
  end

endmodule

// File: rtl/ceespu_gshare_predictor.sv
// Gshare direction predictor: combinational same-cycle lookup, no backpressure (lookups ignored until O_ready).
// Optional statistics counters are built only when CEESPU_BP_STATS_EN is defined.
module ceespu_gshare_predictor
  import ceespu_bp_pkg::*;
#(
  parameter int PC_WIDTH  = 14,
  parameter int PHT_BITS  = 8,
  parameter int HIST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 I_lookup_valid,
  input  logic                 I_lookup_cond,
  input  logic                 I_lookup_uncond,
  input  logic [PC_WIDTH-1:0]  I_lookup_pc,
  output logic                 O_ready,
  output logic                 O_prediction,
  output logic [PHT_BITS-1:0]  O_pht_index,
  output logic [HIST_BITS-1:0] O_history,
  input  logic                 I_update_valid,
  input  logic [PHT_BITS-1:0]  I_update_index,
  input  logic [HIST_BITS-1:0] I_update_history,
  input  logic                 I_update_taken,
  input  logic                 I_update_mispredict,
  output logic [31:0]          O_stat_branches,
  output logic [31:0]          O_stat_mispredicts
);

  state_e                state_q, state_d;
  logic [PHT_BITS-1:0]   ptr_q, ptr_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [HIST_BITS-1:0]  ghr_shift, ghr_recover;
  logic [PHT_BITS-1:0]   lookup_index;
  logic [1:0]            rd_ctr;
  logic                  prediction;
  logic                  wr_en, wr_init;
  logic [PHT_BITS-1:0]   wr_addr;
  logic                  unused_ok;

  assign unused_ok    = ^{I_lookup_pc, I_update_history};
  assign lookup_index = I_lookup_pc[PHT_BITS-1:0] ^ PHT_BITS'(ghr_q);
  assign O_ready      = (state_q == S_RUN);
  assign O_pht_index  = lookup_index;
  assign O_history    = ghr_q;
  assign O_prediction = prediction;

  ceespu_pht_ram #(.ADDR_BITS(PHT_BITS)) u_pht (
    .clk      (clk),
    .rd_addr  (lookup_index),
    .rd_data  (rd_ctr),
    .wr_en    (wr_en & rst_n),
    .wr_init  (wr_init),
    .wr_addr  (wr_addr),
    .wr_taken (I_update_taken)
  );

  always_comb begin
    prediction = 1'b0;
    if (O_ready) begin
      if (I_lookup_uncond)    prediction = 1'b1;
      else if (I_lookup_cond) prediction = rd_ctr[1];
    end
  end

  // A single-bit history has no older bits to keep.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift   = prediction;
      assign ghr_recover = I_update_taken;
    end else begin : g_histn
      assign ghr_shift   = {ghr_q[HIST_BITS-2:0], prediction};
      assign ghr_recover = {I_update_history[HIST_BITS-2:0], I_update_taken};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    wr_en   = 1'b0;
    wr_init = 1'b0;
    wr_addr = I_update_index;
    case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_init = 1'b1;
        wr_addr = ptr_q;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        wr_en = I_update_valid;
        // Recovery wins: a same-cycle lookup is already on the wrong path.
        if (I_update_valid && I_update_mispredict) ghr_d = ghr_recover;
        else if (I_lookup_valid && I_lookup_cond)  ghr_d = ghr_shift;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
    end
  end

`ifdef CEESPU_BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (state_q == S_RUN && I_update_valid) begin
      if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
      if (I_update_mispredict && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign O_stat_branches    = stat_br_q;
  assign O_stat_mispredicts = stat_mp_q;
`else
  assign O_stat_branches    = 32'd0;
  assign O_stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_ceespu_gshare_predictor.sv
// Bench for ceespu_gshare_predictor: directed steps plus randomized traffic against a table/array model.
module tb_ceespu_gshare_predictor;

  logic        clk;
  logic        rst_n;
  logic        I_lookup_valid, I_lookup_cond, I_lookup_uncond;
  logic [13:0] I_lookup_pc;
  logic        O_ready, O_prediction;
  logic [7:0]  O_pht_index, O_history;
  logic        I_update_valid;
  logic [7:0]  I_update_index, I_update_history;
  logic        I_update_taken, I_update_mispredict;
  logic [31:0] O_stat_branches, O_stat_mispredicts;

  ceespu_gshare_predictor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .I_lookup_valid      (I_lookup_valid),
    .I_lookup_cond       (I_lookup_cond),
    .I_lookup_uncond     (I_lookup_uncond),
    .I_lookup_pc         (I_lookup_pc),
    .O_ready             (O_ready),
    .O_prediction        (O_prediction),
    .O_pht_index         (O_pht_index),
    .O_history           (O_history),
    .I_update_valid      (I_update_valid),
    .I_update_index      (I_update_index),
    .I_update_history    (I_update_history),
    .I_update_taken      (I_update_taken),
    .I_update_mispredict (I_update_mispredict),
    .O_stat_branches     (O_stat_branches),
    .O_stat_mispredicts  (O_stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counters as plain integers 0..3, history as an 8-bit value.
  int         m_pht [256];
  logic [7:0] m_ghr;
  bit         m_ready;
  int         m_init_cnt;
  int         m_br, m_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 8'h00; m_ready = 0; m_init_cnt = 0; m_br = 0; m_mp = 0;
  endtask

  // One clock: drive, check combinational outputs against the model, clock, advance the model.
  task automatic cyc(input logic r, input logic lv, input logic lc, input logic lu, input logic [13:0] pc,
                     input logic uv, input logic [7:0] ui, input logic [7:0] uh,
                     input logic ut, input logic um);
    logic [7:0] e_idx;
    logic       e_pred;
    rst_n = r;
    I_lookup_valid = lv; I_lookup_cond = lc; I_lookup_uncond = lu; I_lookup_pc = pc;
    I_update_valid = uv; I_update_index = ui; I_update_history = uh;
    I_update_taken = ut; I_update_mispredict = um;
    #1;
    e_idx  = pc[7:0] ^ m_ghr;
    e_pred = !m_ready ? 1'b0 : lu ? 1'b1 : lc ? (m_pht[e_idx] >= 2) : 1'b0;
    if (r) begin
      chk("ready", 32'(O_ready), 32'(m_ready));
      chk("pred", 32'(O_prediction), 32'(e_pred));
      chk("index", 32'(O_pht_index), 32'(e_idx));
      chk("history", 32'(O_history), 32'(m_ghr));
`ifdef CEESPU_BP_STATS_EN
      chk("stat_br", O_stat_branches, m_br);
      chk("stat_mp", O_stat_mispredicts, m_mp);
`else
      chk("stat_br", O_stat_branches, 0);
      chk("stat_mp", O_stat_mispredicts, 0);
`endif
    end
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == 256) m_ready = 1;
    end else begin
      if (uv) begin
        if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
        m_br++;
        if (um) m_mp++;
      end
      if (uv && um)      m_ghr = {uh[6:0], ut};
      else if (lv && lc) m_ghr = {m_ghr[6:0], e_pred};
    end
    #1;
  endtask

  task automatic peek(input logic lc, input logic lu, input logic [13:0] pc);
    I_lookup_valid = 1'b0; I_lookup_cond = lc; I_lookup_uncond = lu; I_lookup_pc = pc;
    I_update_valid = 1'b0; I_update_mispredict = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    logic lc, lu;
    model_reset();
    cyc(0, 0, 0, 0, 14'h0, 0, 8'h0, 8'h0, 0, 0);
    cyc(0, 0, 0, 0, 14'h0, 0, 8'h0, 8'h0, 0, 0);
    chk("rst_ready", 32'(O_ready), 0);
    chk("rst_history", 32'(O_history), 0);
    chk("rst_stat_br", O_stat_branches, 0);

    // Init length, with random lookups/updates that must be ignored.
    n = 0;
    while (n < 300 && O_ready !== 1'b1) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'b0, 14'($urandom), 1'($urandom), 8'($urandom),
          8'($urandom), 1'($urandom), 1'($urandom));
      n++;
    end
    chk("init_len", n, 256);

    for (int i = 0; i < 256; i++) cyc(1, 0, 1, 0, 14'(i), 0, 8'h0, 8'h0, 0, 0);

    cyc(1, 1, 1, 0, 14'h0040, 0, 8'h0, 8'h0, 0, 0);
    chk("pc40_hist", 32'(O_history), 0);

    // Counter saturation at index 0x40.
    cyc(1, 0, 0, 0, 14'h0, 1, 8'h40, 8'h0, 1, 0);
    peek(1, 0, 14'h0040);
    chk("ctr2_pred", 32'(O_prediction), 1);
    cyc(1, 0, 0, 0, 14'h0, 1, 8'h40, 8'h0, 1, 0);
    cyc(1, 0, 0, 0, 14'h0, 1, 8'h40, 8'h0, 1, 0);
    peek(1, 0, 14'h0040);
    chk("ctr3_pred", 32'(O_prediction), 1);
    cyc(1, 0, 0, 0, 14'h0, 1, 8'h40, 8'h0, 0, 0);
    peek(1, 0, 14'h0040);
    chk("sat_then_nt", 32'(O_prediction), 1);

    // Speculative history: predictions 0,1,1 then an unconditional branch.
    cyc(1, 1, 1, 0, 14'h0010, 0, 8'h0, 8'h0, 0, 0);
    cyc(1, 1, 1, 0, 14'h0040, 0, 8'h0, 8'h0, 0, 0);
    cyc(1, 1, 1, 0, 14'h0041, 0, 8'h0, 8'h0, 0, 0);
    chk("ghr_011", 32'(O_history), 32'h03);
    cyc(1, 1, 0, 1, 14'h0077, 0, 8'h0, 8'h0, 0, 0);
    chk("ghr_uncond", 32'(O_history), 32'h03);

    // Recovery overrides a same-cycle speculative shift.
    cyc(1, 0, 0, 0, 14'h0, 1, 8'h80, 8'h2D, 0, 1);
    chk("ghr_5a", 32'(O_history), 32'h5A);
    cyc(1, 1, 1, 0, 14'h0033, 1, 8'h81, 8'h12, 1, 1);
    chk("ghr_recover", 32'(O_history), 32'h25);

    for (int i = 0; i < 1500; i++) begin
      lc = 1'($urandom);
      lu = lc ? 1'b0 : 1'($urandom);
      cyc(1, 1'($urandom), lc, lu, 14'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Mid-run reset; updates during init must not touch the table.
    cyc(0, 0, 0, 0, 14'h0, 0, 8'h0, 8'h0, 0, 0);
    chk("midrst_ready", 32'(O_ready), 0);
    chk("midrst_history", 32'(O_history), 0);
    n = 0;
    while (n < 300 && O_ready !== 1'b1) begin
      cyc(1, 1, 1, 0, 14'h0005, 1, 8'h05, 8'h0, 1, 1);
      n++;
    end
    chk("reinit_len", n, 256);
    peek(1, 0, 14'h0005);
    chk("init_upd_ignored", 32'(O_prediction), 0);

    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 14'h0, 1, 8'(i + 16), 8'h0, 1, (i < 3));
    peek(0, 0, 14'h0);
`ifdef CEESPU_BP_STATS_EN
    chk("stats_br10", O_stat_branches, 10);
    chk("stats_mp3", O_stat_mispredicts, 3);
`else
    chk("stats_br_off", O_stat_branches, 0);
    chk("stats_mp_off", O_stat_mispredicts, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
